// File: rtl/sc_decrypt_verify_pkg.sv
// Shared widths and FSM encoding for the stream-cipher decrypt-and-verify block.
package sc_decrypt_verify_pkg;

  localparam int WORD_W = 64;
  localparam int TAG_W  = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_TREQ  = 3'd2,
    ST_TWAIT = 3'd3,
    ST_TAG0  = 3'd4,
    ST_TAG1  = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/sc_decrypt_verify.sv
// Decrypts a ciphertext stream with an external keystream, then compares the received
// tag against the core's computed tag in constant time.
module sc_decrypt_verify
  import sc_decrypt_verify_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  ct_len,
  input  logic [WORD_W-1:0] ct_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [WORD_W-1:0] z,
  output logic              sc_step,
  output logic [WORD_W-1:0] pt_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              tag_req,
  input  logic              tag_done,
  input  logic [TAG_W-1:0]  comp_tag,
  input  logic [WORD_W-1:0] tag_in,
  input  logic              tag_valid,
  output logic              tag_ready,
  output logic              busy,
  output logic              done,
  output logic              auth_ok,
  output logic              auth_fail,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // the sender holds data stable while valid is high and ready is low.

  state_e              state_q;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   diff_q;
  logic [TAG_W-1:0]    ctag_q;
  logic [WORD_W-1:0]   pt_data_q;
  logic                pt_valid_q;
  logic                done_q;
  logic                auth_ok_q;
  logic                auth_fail_q;
  logic                ct_hs;
  logic                pt_hs;

  assign cnt_d = cnt_q - LEN_W'(1);

  // A new word is accepted while the output slot is empty or draining this cycle.
  assign ct_ready  = !rst && (state_q == ST_DATA) && (!pt_valid_q || pt_ready);
  assign ct_hs     = ct_valid && ct_ready;
  assign pt_hs     = pt_valid_q && pt_ready;
  assign sc_step   = ct_hs;
  assign tag_req   = !rst && (state_q == ST_TREQ) && !pt_valid_q;
  assign tag_ready = !rst && ((state_q == ST_TAG0) || (state_q == ST_TAG1));
  assign busy      = (state_q != ST_IDLE);

  assign pt_data     = pt_data_q;
  assign pt_valid    = pt_valid_q;
  assign done        = done_q;
  assign auth_ok     = auth_ok_q;
  assign auth_fail   = auth_fail_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      diff_q      <= '0;
      ctag_q      <= '0;
      pt_data_q   <= '0;
      pt_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pt_hs) pt_valid_q <= 1'b0;
      if (ct_hs) begin
        pt_data_q  <= ct_data ^ z;
        pt_valid_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
            cnt_q       <= ct_len;
            state_q     <= (ct_len != '0) ? ST_DATA : ST_TREQ;
          end
        end
        ST_DATA: begin
          if (ct_hs) begin
            cnt_q <= cnt_d;
            if (cnt_q == LEN_W'(1)) state_q <= ST_TREQ;
          end
        end
        ST_TREQ: begin
          if (!pt_valid_q) state_q <= ST_TWAIT;
        end
        ST_TWAIT: begin
          if (tag_done) begin
            ctag_q  <= comp_tag;
            state_q <= ST_TAG0;
          end
        end
        // Both tag words are always consumed so timing never depends on the tag value.
        ST_TAG0: begin
          if (tag_valid) begin
            diff_q  <= tag_in ^ ctag_q[TAG_W-1:WORD_W];
            state_q <= ST_TAG1;
          end
        end
        ST_TAG1: begin
          if (tag_valid) begin
            diff_q  <= diff_q | (tag_in ^ ctag_q[WORD_W-1:0]);
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q      <= 1'b1;
          auth_ok_q   <= (diff_q == '0);
          auth_fail_q <= (diff_q != '0);
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_decrypt_verify.sv
// Directed bench for sc_decrypt_verify: streaming decrypt, backpressure, tag compare, reset.
module tb_sc_decrypt_verify;
  import sc_decrypt_verify_pkg::*;

  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  ct_len;
  logic [63:0]       ct_data;
  logic              ct_valid;
  logic              ct_ready;
  logic [63:0]       z;
  logic              sc_step;
  logic [63:0]       pt_data;
  logic              pt_valid;
  logic              pt_ready;
  logic              tag_req;
  logic              tag_done;
  logic [127:0]      comp_tag;
  logic [63:0]       tag_in;
  logic              tag_valid;
  logic              tag_ready;
  logic              busy;
  logic              done;
  logic              auth_ok;
  logic              auth_fail;
  logic [2:0]        dbg_state;

  sc_decrypt_verify #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ct_len(ct_len),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .z(z), .sc_step(sc_step),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .tag_req(tag_req), .tag_done(tag_done), .comp_tag(comp_tag),
    .tag_in(tag_in), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .busy(busy), .done(done), .auth_ok(auth_ok), .auth_fail(auth_fail),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int cyc = 0;
  int step_cnt, pt_cnt, treq_cnt, tagw_cnt;
  int first_pt_cyc, last_pt_cyc, treq_cyc;

  localparam logic [127:0] CTAG = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: plaintext order/content, step and tag-word counting
  always @(negedge clk) begin
    if (!rst) begin
      if (sc_step) step_cnt++;
      if (tag_req) begin
        treq_cnt++;
        treq_cyc = cyc;
      end
      if (tag_valid && tag_ready) tagw_cnt++;
      if (pt_valid && pt_ready) begin
        if (pt_cnt == 0) first_pt_cyc = cyc;
        last_pt_cyc = cyc;
        pt_cnt++;
        chk("pt_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("pt_data", pt_data, exp_q.pop_front());
      end
    end
  end

  task automatic clear_stats();
    step_cnt = 0; pt_cnt = 0; treq_cnt = 0; tagw_cnt = 0;
    first_pt_cyc = 0; last_pt_cyc = 0; treq_cyc = 0;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_ct_ready"}, 64'(ct_ready), 64'd0);
    chk({pfx, "_sc_step"}, 64'(sc_step), 64'd0);
    chk({pfx, "_pt_data"}, pt_data, 64'd0);
    chk({pfx, "_pt_valid"}, 64'(pt_valid), 64'd0);
    chk({pfx, "_tag_req"}, 64'(tag_req), 64'd0);
    chk({pfx, "_tag_ready"}, 64'(tag_ready), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_auth_ok"}, 64'(auth_ok), 64'd0);
    chk({pfx, "_auth_fail"}, 64'(auth_fail), 64'd0);
    chk({pfx, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // driver: start a message and push n_send words; z for word i is ~i
  task automatic send_msg(input int len, input int n_send, input int stall_at,
                          input int stall_n, input logic [63:0] base);
    int i;
    int c;
    logic hs;
    logic stalled;
    start = 1'b1;
    ct_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    i = 0;
    c = 0;
    while (i < n_send && c < n_send + stall_n + 20) begin
      stalled = (c >= stall_at) && (c < stall_at + stall_n);
      pt_ready = !stalled;
      ct_valid = 1'b1;
      ct_data  = base + 64'(i);
      z        = ~64'(i);
      #1;
      hs = ct_valid && ct_ready;
      if (stalled) begin
        chk("stall_ct_ready", 64'(ct_ready), 64'd0);
        chk("stall_sc_step", 64'(sc_step), 64'd0);
        chk("stall_pt_valid", 64'(pt_valid), 64'd1);
        if (exp_q.size() > 0) chk("stall_pt_data", pt_data, exp_q[0]);
      end
      if (hs) exp_q.push_back((base + 64'(i)) ^ ~64'(i));
      @(posedge clk); #1;
      if (hs) i++;
      c++;
    end
    chk("words_sent", 64'(i), 64'(n_send));
    ct_valid = 1'b0;
    ct_data  = '0;
    pt_ready = 1'b1;
  endtask

  // tag phase: serve tag_req, feed both tag words, check the verdict
  task automatic run_tag(input logic [63:0] w0, input logic [63:0] w1,
                         input logic same_cycle, input logic exp_ok);
    int n;
    n = 0;
    while (!tag_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("treq_seen", 64'(tag_req), 64'd1);
    comp_tag = CTAG;
    if (!same_cycle) begin
      @(posedge clk); #1;
    end
    tag_done = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tag_ready && n < 20);
    tag_done = 1'b0;
    comp_tag = '0;
    chk("tag_ready", 64'(tag_ready), 64'd1);
    tag_valid = 1'b1;
    tag_in = w0;
    @(posedge clk); #1;
    tag_in = w1;
    @(posedge clk); #1;
    tag_valid = 1'b0;
    tag_in = '0;
    chk("fin_tag_ready", 64'(tag_ready), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("auth_ok", 64'(auth_ok), 64'(exp_ok));
    chk("auth_fail", 64'(auth_fail), 64'(!exp_ok));
    chk("busy_end", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("done_once", 64'(done), 64'd0);
    chk("auth_ok_held", 64'(auth_ok), 64'(exp_ok));
    chk("tag_words", 64'(tagw_cnt), 64'd2);
    chk("treq_once", 64'(treq_cnt), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ct_len = '0; ct_data = '0; ct_valid = 1'b0;
    z = '0; pt_ready = 1'b1; tag_done = 1'b0; comp_tag = '0;
    tag_in = '0; tag_valid = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // one-word decrypt and tag match
    clear_stats();
    send_msg(1, 1, 99, 0, 64'h0123_4567_89AB_CDEF);
    chk("one_pt_valid", 64'(pt_valid), 64'd1);
    chk("one_pt", pt_data, 64'hFEDC_BA98_7654_3210);
    chk("one_steps", 64'(step_cnt), 64'd1);
    run_tag(64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b1);

    // streaming four words, tag mismatch in bit 0 of the second word
    clear_stats();
    send_msg(4, 4, 99, 0, 64'hA5A5_0000_1234_0000);
    run_tag(64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFE, 1'b0, 1'b0);
    chk("stream_pts", 64'(pt_cnt), 64'd4);
    chk("stream_back2back", 64'(last_pt_cyc - first_pt_cyc), 64'd3);
    chk("stream_steps", 64'(step_cnt), 64'd4);
    chk("stream_treq_lat", 64'(treq_cyc - last_pt_cyc), 64'd1);

    // backpressure: pt_ready low for three cycles mid-message
    clear_stats();
    send_msg(4, 4, 2, 3, 64'h1357_9BDF_0246_8ACE);
    run_tag(64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 1'b1, 1'b1);
    chk("bp_pts", 64'(pt_cnt), 64'd4);
    chk("bp_steps", 64'(step_cnt), 64'd4);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // zero length goes straight to the tag request
    clear_stats();
    send_msg(0, 0, 99, 0, 64'd0);
    chk("zero_treq_now", 64'(tag_req), 64'd1);
    run_tag(64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b1);
    chk("zero_steps", 64'(step_cnt), 64'd0);

    // reset in DATA after two of five words
    clear_stats();
    send_msg(5, 2, 99, 0, 64'hDEAD_BEEF_0000_0000);
    ct_valid = 1'b1;
    ct_data = 64'h1111_2222_3333_4444;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ct_valid = 1'b0;
    ct_data = '0;
    check_idle_outputs("midrst");
    chk("midrst_steps", 64'(step_cnt), 64'd2);

    // recovery: two-word message, mismatch in the first tag word
    clear_stats();
    send_msg(2, 2, 99, 0, 64'h0F0F_0F0F_F0F0_F0F0);
    run_tag(64'h8011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 1'b1, 1'b0);
    chk("rec_pts", 64'(pt_cnt), 64'd2);
    chk("rec_steps", 64'(step_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_decrypt_verify.md
SC_DECRYPT_VERIFY -- requirements
Module: sc_decrypt_verify

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of ct_len, in 64-bit words.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a message; sampled only in IDLE.
REQ-005 SHALL have port ct_len, input, LEN_W: number of ciphertext words; sampled with start.
REQ-006 SHALL have ports ct_data (input, 64), ct_valid (input, 1) and ct_ready (output, 1): ciphertext word stream.
REQ-007 SHALL have port z, input, 64: current keystream word from the stream-cipher state block, valid combinationally.
REQ-008 SHALL have port sc_step, output, 1: one-cycle pulse that advances the stream-cipher state by 64 rounds.
REQ-009 SHALL have ports pt_data (output, 64), pt_valid (output, 1) and pt_ready (input, 1): plaintext word stream.
REQ-010 SHALL have port tag_req, output, 1: one-cycle pulse that requests tag finalisation from the cipher core.
REQ-011 SHALL have ports tag_done (input, 1) and comp_tag (input, 128): computed tag, valid while tag_done is high.
REQ-012 SHALL have ports tag_in (input, 64), tag_valid (input, 1) and tag_ready (output, 1): received tag, sent as two words, bits 127:64 first.
REQ-013 SHALL have ports busy, done, auth_ok and auth_fail, outputs, 1 each: status; done pulses for one cycle.

Function
REQ-014 SHALL implement states IDLE, DATA, TREQ, TWAIT, TAG0, TAG1 and FIN.
REQ-015 SHALL leave IDLE on start: to DATA if ct_len is not 0, or to TREQ if ct_len is 0; a word counter SHALL load ct_len.
REQ-016 SHALL drive ct_ready = (state == DATA) and (!pt_valid or pt_ready).
REQ-017 SHALL, on a ct handshake, register pt_data = ct_data XOR z and set pt_valid on the next cycle.
REQ-018 SHALL pulse sc_step in the same cycle as the ct handshake; z SHALL be sampled before the step.
REQ-019 SHALL hold pt_data and pt_valid stable until pt_ready; pt_valid SHALL clear on pt_ready unless a new word is accepted in that cycle.
REQ-020 SHALL give full throughput: one word per cycle when ct_valid and pt_ready are held high.
REQ-021 SHALL decrement the counter on each handshake and move to TREQ after the handshake that takes the counter from 1 to 0.
REQ-022 SHALL leave TREQ only once pt_valid is low, pulsing tag_req for exactly one cycle on that exit, then enter TWAIT.
REQ-023 SHALL, in TWAIT, latch comp_tag when tag_done is high, then enter TAG0.
REQ-024 SHALL assert tag_ready only in TAG0 and TAG1.
REQ-025 SHALL set diff = tag_in XOR comp_tag[127:64] on the TAG0 handshake, then enter TAG1.
REQ-026 SHALL update diff = diff OR (tag_in XOR comp_tag[63:0]) on the TAG1 handshake, then enter FIN.
REQ-027 SHALL, in FIN, pulse done, set auth_ok = (diff == 0) and auth_fail = the inverse, then return to IDLE.
REQ-028 SHALL hold auth_ok and auth_fail until the next start, which clears both.
REQ-029 SHALL make the comparison data-independent in timing: both tag words are always consumed and there is no early exit.
REQ-030 SHALL ignore start outside IDLE.
REQ-031 SHALL assert busy in every state except IDLE.
REQ-032 SHALL ignore ct_valid outside DATA and tag_valid outside TAG0/TAG1.
REQ-033 SHALL treat tag_done arriving in the same cycle as the tag_req pulse as valid in the next cycle; tag_done SHALL be held high by the core until it is sampled.

Reset
REQ-034 SHALL, on rst high at a clock edge, enter IDLE and clear the counter, diff and the latched tag, regardless of state (including mid-message).
REQ-035 SHALL reset all outputs to 0: ct_ready, sc_step, pt_data, pt_valid, tag_req, tag_ready, busy, done, auth_ok and auth_fail.
REQ-036 SHALL let rst override start and all handshakes in the same cycle.

Structure
REQ-037 SHALL define the state encoding, the 64-bit word width and the 128-bit tag width in the shared TriviA package.
REQ-038 SHALL be a single module with no sub-modules; the plaintext output register and the FSM SHALL be inline.

Verification
REQ-039 SHALL cover one-word decrypt: ct_len=1, ct=0x0123456789ABCDEF, z=0xFFFFFFFFFFFFFFFF -> pt=0xFEDCBA9876543210 one cycle later, and one sc_step pulse.
REQ-040 SHALL cover streaming: ct_len=4 with ct_valid and pt_ready held high -> 4 pt words on consecutive cycles, 4 sc_step pulses, and tag_req one cycle after the last pt is drained.
REQ-041 SHALL cover backpressure: pt_ready low for 3 cycles mid-message -> ct_ready low, pt_data stable, no sc_step, and no lost or duplicated word.
REQ-042 SHALL cover tag match: comp_tag=0x00112233445566778899AABBCCDDEEFF with equal tag_in words -> done pulse and auth_ok=1.
REQ-043 SHALL cover tag mismatch: the same comp_tag with bit 0 of the second word flipped -> both words consumed, auth_fail=1 and auth_ok=0.
REQ-044 SHALL cover zero length and reset: ct_len=0 -> direct tag_req with no sc_step; rst asserted in DATA after 2 of 5 words -> IDLE next cycle with all outputs 0.
